// File: rtl/aes_pkg.sv
// Shared AES-128 types, constants and GF(2^8) helpers.
// S-box is derived arithmetically (inverse then affine) rather than tabulated.
package aes_pkg;
  localparam int NR = 10;
  localparam int BW = 128;
  localparam int RW = 4;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef logic [BW-1:0] blk_t;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse, and maps 0 to 0
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int i = 0; i < 7; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]}
         ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] mixcol(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic blk_t mixcolumns(input blk_t s);
    blk_t r;
    r = '0;
    for (int c = 0; c < 4; c++)
      r[127-32*c -: 32] = mixcol(s[127-32*c -: 32]);
    return r;
  endfunction

  function automatic logic [7:0] rcon(input logic [RW-1:0] rc);
    logic [7:0] v;
    v = 8'h00;
    unique case (rc)
      4'd1:  v = 8'h01;
      4'd2:  v = 8'h02;
      4'd3:  v = 8'h04;
      4'd4:  v = 8'h08;
      4'd5:  v = 8'h10;
      4'd6:  v = 8'h20;
      4'd7:  v = 8'h40;
      4'd8:  v = 8'h80;
      4'd9:  v = 8'h1b;
      4'd10: v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction
endpackage

// File: rtl/aes128_enc_iter_if.sv
// Plaintext/key in and ciphertext out valid/ready bundle.
interface aes128_enc_iter_if;
  import aes_pkg::*;
  logic in_valid;
  logic in_ready;
  blk_t pt;
  blk_t key;
  logic out_valid;
  logic out_ready;
  blk_t ct;

  modport master (
    output in_valid, pt, key, out_ready,
    input  in_ready, out_valid, ct
  );
  modport slave (
    input  in_valid, pt, key, out_ready,
    output in_ready, out_valid, ct
  );
endinterface

// File: rtl/KeyGeneration.sv
// One step of the AES-128 key schedule for round rc.
module KeyGeneration
  import aes_pkg::*;
(
  input  logic [RW-1:0] rc,
  input  blk_t          keyin,
  output blk_t          keyout
);
  logic [31:0] w0, w1, w2, w3, t;
  logic [31:0] n0, n1, n2, n3;

  assign {w0, w1, w2, w3} = keyin;
  assign t = {sbox(w3[23:16]), sbox(w3[15:8]),
              sbox(w3[7:0]), sbox(w3[31:24])}
           ^ {rcon(rc), 24'h0};
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;
  assign keyout = {n0, n1, n2, n3};
endmodule

// File: rtl/final_round.sv
// Last AES round: same as a full round but without MixColumns.
module final_round
  import aes_pkg::*;
(
  input  logic [RW-1:0] rc,
  input  blk_t          data,
  input  blk_t          keyin,
  output blk_t          rndout,
  output blk_t          keyout
);
  blk_t sb, sr;

  subbytes u_sb (.din(data), .dout(sb));
  shiftrow u_sr (.din(sb), .dout(sr));
  KeyGeneration u_kg (.rc(rc), .keyin(keyin), .keyout(keyout));

  assign rndout = sr ^ keyout;
endmodule

// File: rtl/rounds.sv
// Full AES round with MixColumns and on-the-fly key expansion.
module rounds
  import aes_pkg::*;
(
  input  logic [RW-1:0] rc,
  input  blk_t          data,
  input  blk_t          keyin,
  output blk_t          rndout,
  output blk_t          keyout
);
  blk_t sb, sr;

  subbytes u_sb (.din(data), .dout(sb));
  shiftrow u_sr (.din(sb), .dout(sr));
  KeyGeneration u_kg (.rc(rc), .keyin(keyin), .keyout(keyout));

  assign rndout = mixcolumns(sr) ^ keyout;
endmodule

// File: rtl/shiftrow.sv
// ShiftRows: row r of the column-major state rotates left by r.
module shiftrow
  import aes_pkg::*;
(
  input  blk_t din,
  output blk_t dout
);
  for (genvar c = 0; c < 4; c++) begin : g_c
    for (genvar r = 0; r < 4; r++) begin : g_r
      assign dout[127-8*(4*c+r) -: 8] =
        din[127-8*(4*((c+r)%4)+r) -: 8];
    end
  end
endmodule

// File: rtl/subbytes.sv
// Byte-wise S-box substitution over the 128-bit state.
module subbytes
  import aes_pkg::*;
(
  input  blk_t din,
  output blk_t dout
);
  for (genvar i = 0; i < 16; i++) begin : g_sb
    assign dout[8*i +: 8] = sbox(din[8*i +: 8]);
  end
endmodule

// File: rtl/aes128_enc_iter.sv
// Iterative AES-128 encryptor: one round per clock, 12-cycle initiation.
module aes128_enc_iter
  import aes_pkg::*;
#(
  parameter int NR = aes_pkg::NR
) (
  input  logic clk,
  input  logic rst,
  aes128_enc_iter_if.slave bus
);
  state_t        state, state_n;
  blk_t          st, st_n;
  blk_t          rk, rk_n;
  logic [RW-1:0] rnd, rnd_n;
  blk_t          mid_st, mid_k;
  blk_t          fin_st, fin_k;

  rounds u_rounds (
    .rc(rnd), .data(st), .keyin(rk),
    .rndout(mid_st), .keyout(mid_k)
  );

  final_round u_final (
    .rc(rnd), .data(st), .keyin(rk),
    .rndout(fin_st), .keyout(fin_k)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      st    <= '0;
      rk    <= '0;
      rnd   <= '0;
    end else begin
      state <= state_n;
      st    <= st_n;
      rk    <= rk_n;
      rnd   <= rnd_n;
    end
  end

  always_comb begin
    state_n = state;
    st_n    = st;
    rk_n    = rk;
    rnd_n   = rnd;
    unique case (state)
      IDLE: begin
        if (bus.in_valid) begin
          st_n    = bus.pt ^ bus.key;
          rk_n    = bus.key;
          rnd_n   = RW'(1);
          state_n = RUN;
        end
      end
      RUN: begin
        if (rnd == RW'(NR)) begin
          st_n    = fin_st;
          rk_n    = fin_k;
          state_n = DONE;
        end else begin
          st_n  = mid_st;
          rk_n  = mid_k;
          rnd_n = rnd + RW'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // handshake outputs depend on the state register only
  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.ct        = (state == DONE) ? st : '0;
endmodule
